// File: rtl/wb_result_select_pipe.sv
// Writeback result selector: picks one of NUM_IN candidates, formats load data,
// and holds results in an output register backed by a one-entry skid buffer.
module wb_result_select_pipe #(
    parameter int XLEN   = 32,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = $clog2(NUM_IN),
    parameter int LD_IDX = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_IN*XLEN-1:0] in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic [4:0]             in_rd,
    input  logic [2:0]             in_ld_fmt,
    input  logic [1:0]             in_addr_lo,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_result,
    output logic [4:0]             out_rd,
    output logic                   out_misalign
);

    localparam logic [2:0] F_LB  = 3'b000;
    localparam logic [2:0] F_LH  = 3'b001;
    localparam logic [2:0] F_LW  = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100;
    localparam logic [2:0] F_LHU = 3'b101;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] cand,
                                                 input logic [2:0]      fmt,
                                                 input logic [1:0]      lo);
        logic [XLEN-1:0]    sh;
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        sh  = cand >> {lo, 3'b000};
        b_s = signed'(sh[7:0]);
        h_s = signed'(sh[15:0]);
        case (fmt)
            F_LB:    fmt_load = XLEN'(b_s);
            F_LBU:   fmt_load = {{(XLEN-8){1'b0}}, sh[7:0]};
            F_LH:    fmt_load = XLEN'(h_s);
            F_LHU:   fmt_load = {{(XLEN-16){1'b0}}, sh[15:0]};
            F_LW:    fmt_load = sh;
            default: fmt_load = cand;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] fmt, input logic [1:0] lo);
        is_misaligned = ((fmt == F_LH || fmt == F_LHU) && lo == 2'd3) ||
                        (fmt == F_LW && lo != 2'd0);
    endfunction

    logic [XLEN-1:0] cand_p0;
    logic [XLEN-1:0] res_p0;
    logic            mis_p0;

    logic [XLEN-1:0] skid_result_p1;
    logic [4:0]      skid_rd_p1;
    logic            skid_mis_p1;

    state_t state, state_nxt;
    logic   accept, drain;
    logic   ld_oreg_in, ld_oreg_skid, ld_skid;

    // ---- stage p0: candidate select and load formatting (combinational)
    always_comb begin
        cand_p0 = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) cand_p0 = in_data[k*XLEN +: XLEN];
        end
        res_p0 = cand_p0;
        mis_p0 = 1'b0;
        if (in_sel == SEL_W'(LD_IDX)) begin
            res_p0 = fmt_load(cand_p0, in_ld_fmt, in_addr_lo);
            mis_p0 = is_misaligned(in_ld_fmt, in_addr_lo);
        end
        if (in_rd == 5'd0) begin
            res_p0 = '0;
            mis_p0 = 1'b0;
        end
    end

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_nxt    = state;
        ld_oreg_in   = 1'b0;
        ld_oreg_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state_nxt  = ONE;
                    ld_oreg_in = 1'b1;
                end
                ONE: begin
                    if (accept && drain) begin
                        ld_oreg_in = 1'b1;
                    end else if (accept) begin
                        state_nxt = FULL;
                        ld_skid   = 1'b1;
                    end else if (drain) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: if (drain) begin
                    state_nxt    = ONE;
                    ld_oreg_skid = 1'b1;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // ---- stage p1: output register and skid buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result     <= '0;
            out_rd         <= '0;
            out_misalign   <= 1'b0;
            skid_result_p1 <= '0;
            skid_rd_p1     <= '0;
            skid_mis_p1    <= 1'b0;
        end else begin
            if (ld_oreg_in) begin
                out_result   <= res_p0;
                out_rd       <= in_rd;
                out_misalign <= mis_p0;
            end else if (ld_oreg_skid) begin
                out_result   <= skid_result_p1;
                out_rd       <= skid_rd_p1;
                out_misalign <= skid_mis_p1;
            end
            if (ld_skid) begin
                skid_result_p1 <= res_p0;
                skid_rd_p1     <= in_rd;
                skid_mis_p1    <= mis_p0;
            end
        end
    end

endmodule
